bp_pred_tracker: RTL and testbench
==================================

// Module: bp_pred_tracker
// PURPOSE
//   Sits downstream of the branch predictor. Records each issued branch prediction in an in-order FIFO.
//   Checks the oldest entry against the execute-stage resolution and flags mispredicts with a redirect PC.
//   Drives the predictor training interface (one update per resolved branch).
//   Clears wrong-path entries on mispredict or pipeline flush.
// PARAMETERS
//   Depth    4   FIFO entries (power of two, >=2)
//   PcWidth  32  PC/target width
// PORTS
//   clk_i               in   1        clock; single clock domain
//   rst_i               in   1        synchronous, active-high reset
//   pred_valid_i        in   1        predictor issued a prediction for a fetched branch/jump
//   pred_ready_o        out  1        FIFO can accept (= !full)
//   pred_pc_i           in   PcWidth  PC of predicted instruction
//   pred_taken_i        in   1        predicted direction
//   pred_target_i       in   PcWidth  predicted target (valid when taken)
//   res_valid_i         in   1        execute resolved a branch/jump this cycle
//   res_pc_i            in   PcWidth  resolved instruction PC
//   res_taken_i         in   1        actual direction
//   res_target_i        in   PcWidth  actual taken target
//   res_compressed_i    in   1        resolved instruction is 16-bit
//   flush_i             in   1        pipeline flush (exception/CSR); discard all entries
//   mispredict_o        out  1        1-cycle pulse: resolution disagreed with prediction
//   redirect_pc_o       out  PcWidth  correct next PC, valid with mispredict_o
//   ex_br_valid_o       out  1        1-cycle training pulse to predictor
//   ex_br_instr_addr_o  out  PcWidth  PC to train
//   ex_br_taken_o       out  1        outcome to train
//   count_o             out  clog2(Depth)+1  occupancy
// BEHAVIOUR
//   - Reset: FIFO empty, count_o=0, pred_ready_o=1, all pulse outputs 0, data outputs 0.
//   - Push: pred_valid_i & pred_ready_o stores {pc,taken,target} at tail. pred_valid_i while full is ignored (no overwrite).
//   - Resolve (res_valid_i): compare with head entry. Outputs are registered and appear exactly 1 cycle after res_valid_i.
//       * match = !empty & head.pc==res_pc_i
//       * mispredict = !match | head.taken!=res_taken_i | (res_taken_i & head.target!=res_target_i)
//       * ex_br_valid_o=1 for every resolution, including orphans; addr=res_pc_i, taken=res_taken_i.
//       * redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + (res_compressed_i ? 2 : 4).
//         Wrap-around mod 2^PcWidth.
//       * correct & match: pop head.
//       * mispredict: clear the entire FIFO (younger entries are wrong-path). A same-cycle push is dropped.
//   - Same-cycle push+pop with no mispredict: count unchanged. Allowed when full only if a pop occurs;
//     pred_ready_o stays registered-full-based (no combinational ready from res_valid_i).
//   - flush_i: clear FIFO next cycle and drop any same-cycle push.
//     A same-cycle res_valid_i still produces its training pulse and mispredict/redirect outputs.
//   - Pointers wrap modulo Depth. count_o ranges 0..Depth.
//   - Reset mid-operation: all state discarded next edge; pending outputs forced to 0.
// CONFIGURATION
//   BP_TRACKER_PERF_EN defined:
//     - Adds outputs perf_br_cnt_o[31:0] and perf_mispred_cnt_o[31:0].
//     - perf_br_cnt_o counts resolutions; perf_mispred_cnt_o counts mispredict_o pulses.
//     - Both are saturating at 32'hFFFF_FFFF and reset to 0.
//   BP_TRACKER_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//   1. Push {pc=0x100,T,tgt=0x80}; resolve pc=0x100,T,0x80 -> next cycle ex_br_valid_o=1, mispredict_o=0, count_o=0.
//   2. Push {0x200,NT}; resolve 0x200,T,0x240 -> mispredict_o=1, redirect_pc_o=0x240, FIFO cleared.
//   3. Push {0x300,T,0x400}; resolve 0x300,NT,compressed=1 -> mispredict_o=1, redirect_pc_o=0x302.
//   4. Push Depth=4 entries; pred_ready_o=0 and a 5th push is ignored.
//      Resolve head correct with a same-cycle push -> count_o stays 4, order preserved.
//   5. Empty FIFO, resolve pc=0x500,NT -> ex_br_valid_o=1, mispredict_o=1, redirect_pc_o=0x504.
//      pc=0xFFFF_FFFC,NT -> redirect_pc_o=0x0.
//   6. Fill 3 entries, assert flush_i with a push -> count_o=0 next cycle.
//      Assert rst_i mid-stream -> all outputs 0. With BP_TRACKER_PERF_EN, counters match the pulse totals.

Source files
------------

// File: rtl/bp_pred_tracker.sv
// In-order tracker of issued branch predictions: checks the oldest entry against execute
// resolution, flags mispredicts with a redirect PC and drives predictor training.
// Optional macro BP_TRACKER_PERF_EN adds saturating resolution/mispredict counters.
module bp_pred_tracker #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned PcWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [PcWidth-1:0]       pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [PcWidth-1:0]       pred_target_i,
    input  logic                     res_valid_i,
    input  logic [PcWidth-1:0]       res_pc_i,
    input  logic                     res_taken_i,
    input  logic [PcWidth-1:0]       res_target_i,
    input  logic                     res_compressed_i,
    input  logic                     flush_i,
    output logic                     mispredict_o,
    output logic [PcWidth-1:0]       redirect_pc_o,
    output logic                     ex_br_valid_o,
    output logic [PcWidth-1:0]       ex_br_instr_addr_o,
    output logic                     ex_br_taken_o,
    output logic [$clog2(Depth):0]   count_o
`ifdef BP_TRACKER_PERF_EN
    ,
    output logic [31:0]              perf_br_cnt_o,
    output logic [31:0]              perf_mispred_cnt_o
`endif
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [PcWidth-1:0] pc;
        logic               taken;
        logic [PcWidth-1:0] target;
    } entry_t;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   head_q;
    logic [PtrW-1:0]   tail_q;

    entry_t            head_e;
    logic              empty;
    logic              full;
    logic              match;
    logic              mispred;
    logic              pop;
    logic              clear;
    logic              push;
    logic [PcWidth-1:0] redirect_pc;
    logic [CntW-1:0]   count_n;

    // Head compare, push/pop/clear decisions and next occupancy
    always_comb begin
        head_e      = mem_q[head_q];
        empty       = (count_o == '0);
        full        = (count_o == CntW'(Depth));
        match       = !empty && (head_e.pc == res_pc_i);
        mispred     = res_valid_i && (!match || (head_e.taken != res_taken_i) ||
                      (res_taken_i && (head_e.target != res_target_i)));
        pop         = res_valid_i && !mispred;
        clear       = mispred || flush_i;
        // a full FIFO still accepts a push in the cycle its head retires
        push        = pred_valid_i && (!full || pop) && !clear;
        redirect_pc = res_taken_i ? res_target_i
                                  : res_pc_i + (res_compressed_i ? PcWidth'(2) : PcWidth'(4));
        count_n     = clear ? '0 : count_o + CntW'(push) - CntW'(pop);
    end

    // Entry storage; needs no reset since occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};
        end
    end

    // Pointers, occupancy and registered resolution outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_o            <= '0;
            pred_ready_o       <= 1'b1;
            mispredict_o       <= 1'b0;
            redirect_pc_o      <= '0;
            ex_br_valid_o      <= 1'b0;
            ex_br_instr_addr_o <= '0;
            ex_br_taken_o      <= 1'b0;
        end else begin
            if (clear) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                head_q <= head_q + PtrW'(pop);
                tail_q <= tail_q + PtrW'(push);
            end
            count_o       <= count_n;
            pred_ready_o  <= (count_n != CntW'(Depth));
            mispredict_o  <= mispred;
            ex_br_valid_o <= res_valid_i;
            if (res_valid_i) begin
                ex_br_instr_addr_o <= res_pc_i;
                ex_br_taken_o      <= res_taken_i;
            end
            if (mispred) begin
                redirect_pc_o <= redirect_pc;
            end
        end
    end

`ifdef BP_TRACKER_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_br_cnt_o      <= '0;
            perf_mispred_cnt_o <= '0;
        end else begin
            if (res_valid_i && (perf_br_cnt_o != 32'hFFFF_FFFF)) begin
                perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
            end
            if (mispred && (perf_mispred_cnt_o != 32'hFFFF_FFFF)) begin
                perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_pred_tracker.sv
// Directed bench for bp_pred_tracker: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_bp_pred_tracker;

    localparam int unsigned Depth   = 4;
    localparam int unsigned PcWidth = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        res_compressed_i;
    logic        flush_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        ex_br_valid_o;
    logic [31:0] ex_br_instr_addr_o;
    logic        ex_br_taken_o;
    logic [2:0]  count_o;
`ifdef BP_TRACKER_PERF_EN
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_mispred_cnt_o;
`endif

    bp_pred_tracker #(.Depth(Depth), .PcWidth(PcWidth)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .pred_valid_i       (pred_valid_i),
        .pred_ready_o       (pred_ready_o),
        .pred_pc_i          (pred_pc_i),
        .pred_taken_i       (pred_taken_i),
        .pred_target_i      (pred_target_i),
        .res_valid_i        (res_valid_i),
        .res_pc_i           (res_pc_i),
        .res_taken_i        (res_taken_i),
        .res_target_i       (res_target_i),
        .res_compressed_i   (res_compressed_i),
        .flush_i            (flush_i),
        .mispredict_o       (mispredict_o),
        .redirect_pc_o      (redirect_pc_o),
        .ex_br_valid_o      (ex_br_valid_o),
        .ex_br_instr_addr_o (ex_br_instr_addr_o),
        .ex_br_taken_o      (ex_br_taken_o),
        .count_o            (count_o)
`ifdef BP_TRACKER_PERF_EN
        ,
        .perf_br_cnt_o      (perf_br_cnt_o),
        .perf_mispred_cnt_o (perf_mispred_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        exp_mis, exp_bv, exp_taken, exp_ready;
    logic [31:0] exp_redirect, exp_addr;
    int          exp_count;
    logic [31:0] exp_pbr, exp_pmis;
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour: a queue of predictions, evaluated at each active edge
    task automatic model_step();
        logic mis;
        if (rst_i) begin
            q.delete();
            exp_mis = 0; exp_bv = 0; exp_taken = 0; exp_redirect = 0; exp_addr = 0;
            exp_pbr = 0; exp_pmis = 0;
        end else begin
            mis    = 0;
            exp_bv = res_valid_i;
            if (res_valid_i) begin
                if (q.size() == 0 || q[0].pc != res_pc_i) mis = 1;
                else mis = (q[0].taken != res_taken_i) || (res_taken_i && q[0].tgt != res_target_i);
                exp_addr  = res_pc_i;
                exp_taken = res_taken_i;
                if (mis) exp_redirect = res_taken_i ? res_target_i
                                                    : res_pc_i + (res_compressed_i ? 32'd2 : 32'd4);
                if (exp_pbr != 32'hFFFF_FFFF) exp_pbr++;
                if (mis && exp_pmis != 32'hFFFF_FFFF) exp_pmis++;
            end
            exp_mis = mis;
            if (flush_i || mis) begin
                q.delete();
            end else begin
                if (res_valid_i) void'(q.pop_front());
                if (pred_valid_i && q.size() < Depth)
                    q.push_back('{pc: pred_pc_i, taken: pred_taken_i, tgt: pred_target_i});
            end
        end
        exp_count = q.size();
        exp_ready = (q.size() < Depth);
    endtask

    task automatic compare_all();
        chk("count", 64'(count_o), 64'(exp_count));
        chk("ready", 64'(pred_ready_o), 64'(exp_ready));
        chk("mispredict", 64'(mispredict_o), 64'(exp_mis));
        chk("ex_br_valid", 64'(ex_br_valid_o), 64'(exp_bv));
        if (exp_bv) begin
            chk("ex_br_addr", 64'(ex_br_instr_addr_o), 64'(exp_addr));
            chk("ex_br_taken", 64'(ex_br_taken_o), 64'(exp_taken));
        end
        if (exp_mis) chk("redirect", 64'(redirect_pc_o), 64'(exp_redirect));
`ifdef BP_TRACKER_PERF_EN
        chk("perf_br", 64'(perf_br_cnt_o), 64'(exp_pbr));
        chk("perf_mis", 64'(perf_mispred_cnt_o), 64'(exp_pmis));
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic idle();
        pred_valid_i = 0; pred_pc_i = 0; pred_taken_i = 0; pred_target_i = 0;
        res_valid_i = 0; res_pc_i = 0; res_taken_i = 0; res_target_i = 0;
        res_compressed_i = 0; flush_i = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        pred_valid_i = 1; pred_pc_i = pc; pred_taken_i = tk; pred_target_i = tgt;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic comp);
        res_valid_i = 1; res_pc_i = pc; res_taken_i = tk; res_target_i = tgt;
        res_compressed_i = comp;
    endtask

    initial begin
        idle();
        rst_i = 1;
        tick();
        tick();
        chk("rst_count_lit", 64'(count_o), 64'd0);
        chk("rst_ready_lit", 64'(pred_ready_o), 64'd1);
        chk("rst_redirect_lit", 64'(redirect_pc_o), 64'd0);
        chk("rst_addr_lit", 64'(ex_br_instr_addr_o), 64'd0);
        rst_i = 0;

        // correctly predicted taken branch
        push(32'h100, 1, 32'h80); tick(); idle();
        resolve(32'h100, 1, 32'h80, 0); tick(); idle();
        chk("t1_bv_lit", 64'(ex_br_valid_o), 64'd1);
        chk("t1_mis_lit", 64'(mispredict_o), 64'd0);
        chk("t1_count_lit", 64'(count_o), 64'd0);

        // predicted not-taken, actually taken
        push(32'h200, 0, 32'h0); tick(); idle();
        resolve(32'h200, 1, 32'h240, 0); tick(); idle();
        chk("t2_mis_lit", 64'(mispredict_o), 64'd1);
        chk("t2_redirect_lit", 64'(redirect_pc_o), 64'h240);
        chk("t2_count_lit", 64'(count_o), 64'd0);

        // predicted taken, actually not-taken compressed
        push(32'h300, 1, 32'h400); tick(); idle();
        resolve(32'h300, 0, 32'h0, 1); tick(); idle();
        chk("t3_redirect_lit", 64'(redirect_pc_o), 64'h302);

        // fill, overflow attempt, push+pop while full, drain in order
        for (int i = 0; i < 4; i++) begin
            push(32'h10 + 32'(4 * i), 0, 32'h0); tick();
        end
        chk("t4_full_ready_lit", 64'(pred_ready_o), 64'd0);
        push(32'h20, 0, 32'h0); tick(); idle();
        chk("t4_ignored_count_lit", 64'(count_o), 64'd4);
        resolve(32'h10, 0, 32'h0, 0); push(32'h24, 0, 32'h0); tick(); idle();
        chk("t4_pushpop_count_lit", 64'(count_o), 64'd4);
        chk("t4_pushpop_mis_lit", 64'(mispredict_o), 64'd0);
        resolve(32'h14, 0, 32'h0, 0); tick();
        resolve(32'h18, 0, 32'h0, 0); tick();
        resolve(32'h1C, 0, 32'h0, 0); tick();
        resolve(32'h24, 0, 32'h0, 0); tick(); idle();
        chk("t4_order_mis_lit", 64'(mispredict_o), 64'd0);
        chk("t4_drained_lit", 64'(count_o), 64'd0);

        // orphan resolutions, including PC wrap
        resolve(32'h500, 0, 32'h0, 0); tick(); idle();
        chk("t5_mis_lit", 64'(mispredict_o), 64'd1);
        chk("t5_redirect_lit", 64'(redirect_pc_o), 64'h504);
        resolve(32'hFFFF_FFFC, 0, 32'h0, 0); tick(); idle();
        chk("t5_wrap_lit", 64'(redirect_pc_o), 64'h0);

        // mispredict on the oldest of several drops younger entries and a same-cycle push
        push(32'h600, 0, 32'h0); tick();
        push(32'h604, 1, 32'h700); tick(); idle();
        resolve(32'h600, 1, 32'h640, 0); push(32'h608, 0, 32'h0); tick(); idle();
        chk("t5b_clear_lit", 64'(count_o), 64'd0);

        // flush with same-cycle push and resolution
        for (int i = 0; i < 3; i++) begin
            push(32'h800 + 32'(4 * i), 0, 32'h0); tick();
        end
        flush_i = 1; push(32'h80C, 0, 32'h0); resolve(32'h800, 0, 32'h0, 0); tick(); idle();
        chk("t6_flush_count_lit", 64'(count_o), 64'd0);
        chk("t6_flush_bv_lit", 64'(ex_br_valid_o), 64'd1);

        // reset mid-stream with pending resolution
        push(32'h900, 1, 32'h940); tick();
        push(32'h904, 0, 32'h0); tick(); idle();
        rst_i = 1; resolve(32'h900, 0, 32'h0, 0); tick(); idle();
        chk("t6_rst_mis_lit", 64'(mispredict_o), 64'd0);
        chk("t6_rst_bv_lit", 64'(ex_br_valid_o), 64'd0);
        chk("t6_rst_count_lit", 64'(count_o), 64'd0);
        rst_i = 0;
        push(32'hA00, 0, 32'h0); tick(); idle();
        resolve(32'hA00, 0, 32'h0, 0); tick(); idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
